// File: rtl/music_player.sv
// music_player: walks a note ROM one slot at a time and plays each note as a square wave.
// Define MUSIC_PLAYER_LOOP_EN to restart from address 0 after LAST_ADDR instead of ending in DONE.
module music_player #(
    parameter int unsigned TEMPO_DIV = 6250000,
    parameter int unsigned LAST_ADDR = 241
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_note,
    output logic       speaker,
    output logic [7:0] cur_note,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, DONE} state_e;

    localparam logic [23:0] TEMPO_LAST = 24'(TEMPO_DIV - 1);
    localparam logic [7:0]  LAST       = 8'(LAST_ADDR);

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  note_q, note_d;
    logic [23:0] tempo_q, tempo_d;
    logic [16:0] div_q, div_d;
    logic        spk_q, spk_d;

    logic        silent;
    logic [7:0]  octave;
    logic [7:0]  semitone;
    logic [9:0]  base;
    logic [2:0]  shamt;
    logic [16:0] half_last;

    // Half-period of the current note: base count for the semitone, doubled per octave below 7.
    always_comb begin
        silent   = (note_q == 8'd0) || (note_q >= 8'd96);
        octave   = note_q / 8'd12;
        semitone = note_q % 8'd12;
        shamt    = 3'(8'd7 - octave);
        case (semitone)
            8'd0:    base = 10'd512;
            8'd1:    base = 10'd483;
            8'd2:    base = 10'd456;
            8'd3:    base = 10'd431;
            8'd4:    base = 10'd406;
            8'd5:    base = 10'd384;
            8'd6:    base = 10'd362;
            8'd7:    base = 10'd342;
            8'd8:    base = 10'd323;
            8'd9:    base = 10'd304;
            8'd10:   base = 10'd287;
            default: base = 10'd271;
        endcase
        half_last = (17'(base) << shamt) - 17'd1;
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d = state_q;
        addr_d  = addr_q;
        note_d  = note_q;
        tempo_d = tempo_q;
        div_d   = div_q;
        spk_d   = spk_q;
        if (stop) begin
            state_d = IDLE;
            addr_d  = 8'd0;
            note_d  = 8'd0;
            tempo_d = 24'd0;
            div_d   = 17'd0;
            spk_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    div_d = 17'd0;
                    spk_d = 1'b0;
                    if (start) begin
                        addr_d  = 8'd0;
                        state_d = FETCH;
                    end
                end
                FETCH: state_d = LATCH;
                LATCH: begin
                    note_d  = rom_note;
                    tempo_d = 24'd0;
                    div_d   = 17'd0;
                    spk_d   = 1'b0;
                    state_d = PLAY;
                end
                PLAY: begin
                    if (silent) begin
                        div_d = 17'd0;
                        spk_d = 1'b0;
                    end else if (div_q == half_last) begin
                        div_d = 17'd0;
                        spk_d = ~spk_q;
                    end else begin
                        div_d = div_q + 17'd1;
                    end
                    if (tempo_q == TEMPO_LAST) begin
                        tempo_d = 24'd0;
                        div_d   = 17'd0;
                        spk_d   = 1'b0;
                        state_d = FETCH;
                        if (addr_q != LAST) begin
                            addr_d = addr_q + 8'd1;
                        end else begin
`ifdef MUSIC_PLAYER_LOOP_EN
                            addr_d = 8'd0;
`else
                            note_d  = 8'd0;
                            state_d = DONE;
`endif
                        end
                    end else begin
                        tempo_d = tempo_q + 24'd1;
                    end
                end
                DONE: begin
                    note_d  = 8'd0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 8'd0;
            note_q  <= 8'd0;
            tempo_q <= 24'd0;
            div_q   <= 17'd0;
            spk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            tempo_q <= tempo_d;
            div_q   <= div_d;
            spk_q   <= spk_d;
        end
    end

    assign rom_addr = addr_q;
    assign cur_note = note_q;
    assign speaker  = spk_q;
    assign busy     = (state_q == FETCH) || (state_q == LATCH) || (state_q == PLAY);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_music_player.sv
// tb_music_player: directed and randomized checks of music_player against a slot/tone reference model.
// Three instances share one clock: a short-tempo sequencer, a long-slot tone probe and a random-note probe.
module tb_music_player;

    localparam int T0 = 4;
    localparam int L0 = 3;
    localparam int SLOT = T0 + 2;
    localparam int NA = L0 + 1;
    localparam int TOTAL = NA * SLOT;
    localparam int T1 = 32800;
    localparam int L1 = 1;
    localparam int T2 = 2100;
    localparam int L2 = 5;
`ifdef MUSIC_PLAYER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    logic start0 = 1'b0, stop0 = 1'b0, spk0, busy0, done0;
    logic [7:0] addr0, note0, cur0;
    logic start1 = 1'b0, stop1 = 1'b0, spk1, busy1, done1;
    logic [7:0] addr1, note1, cur1;
    logic start2 = 1'b0, stop2 = 1'b0, spk2, busy2, done2;
    logic [7:0] addr2, note2, cur2;

    logic [7:0] rom0 [256];
    logic [7:0] rom1 [256];
    logic [7:0] rom2 [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        note0 <= rom0[addr0];
        note1 <= rom1[addr1];
        note2 <= rom2[addr2];
    end

    music_player #(.TEMPO_DIV(T0), .LAST_ADDR(L0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0), .rom_addr(addr0),
        .rom_note(note0), .speaker(spk0), .cur_note(cur0), .busy(busy0), .done(done0));
    music_player #(.TEMPO_DIV(T1), .LAST_ADDR(L1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .rom_addr(addr1),
        .rom_note(note1), .speaker(spk1), .cur_note(cur1), .busy(busy1), .done(done1));
    music_player #(.TEMPO_DIV(T2), .LAST_ADDR(L2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .rom_addr(addr2),
        .rom_note(note2), .speaker(spk2), .cur_note(cur2), .busy(busy2), .done(done2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tone reference: clocks per half period, 0 for silence.
    function automatic int half_period(input int note);
        int c [12] = '{512, 483, 456, 431, 406, 384, 362, 342, 323, 304, 287, 271};
        if (note == 0 || note >= 96) return 0;
        return c[note % 12] << (7 - note / 12);
    endfunction

    function automatic bit exp_spk(input int note, input int j);
        int h = half_period(note);
        if (h == 0) return 1'b0;
        return ((j / h) % 2) == 1;
    endfunction

    // Expected sequencer outputs k cycles after the start edge (k=0 is the first FETCH cycle).
    function automatic void model(input int k, input bit hold, output bit eb, output bit ed,
                                  output bit ea, output logic [7:0] eaddr, output logic [7:0] en);
        int kk = k;
        int slot, ph;
        eb = 1'b0; ed = 1'b0; ea = 1'b0; eaddr = 8'd0; en = 8'd0;
        if (!LOOP && hold) kk = k % (TOTAL + 2);
        if (LOOP || kk < TOTAL) begin
            slot = kk / SLOT;
            ph = kk % SLOT;
            eb = 1'b1;
            ea = 1'b1;
            eaddr = 8'(slot % NA);
            if (ph >= 2) en = rom0[slot % NA];
            else if (slot != 0) en = rom0[(slot - 1) % NA];
        end else if (kk == TOTAL) begin
            ed = 1'b1;
        end
    endfunction

    task automatic run_song(input int stop_k, input int pulse_k, input bit hold);
        bit eb, ed, ea;
        logic [7:0] eaddr, en;
        start0 = 1'b1;
        step();
        for (int k = 0; k <= stop_k; k++) begin
            model(k, hold, eb, ed, ea, eaddr, en);
            check($sformatf("busy@%0d", k), 32'(busy0), 32'(eb));
            check($sformatf("done@%0d", k), 32'(done0), 32'(ed));
            check($sformatf("cur_note@%0d", k), 32'(cur0), 32'(en));
            check($sformatf("speaker@%0d", k), 32'(spk0), 32'd0);
            if (ea) check($sformatf("rom_addr@%0d", k), 32'(addr0), 32'(eaddr));
            start0 = hold || (k == pulse_k);
            stop0 = (k == stop_k);
            step();
        end
        start0 = 1'b0;
        stop0 = 1'b0;
        check("stop_busy", 32'(busy0), 32'd0);
        check("stop_addr", 32'(addr0), 32'd0);
        check("stop_note", 32'(cur0), 32'd0);
        check("stop_spk", 32'(spk0), 32'd0);
        check("stop_done", 32'(done0), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("idle_busy", 32'(busy0), 32'd0);
            check("idle_done", 32'(done0), 32'd0);
        end
    endtask

    // Long-slot probe: note 25 full period, note 12 first toggle.
    task automatic tone_probe();
        int rise, fall, h;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int s = 0; s <= L1; s++) begin
            check("t1_fetch_spk", 32'(spk1), 32'd0);
            step();
            check("t1_latch_spk", 32'(spk1), 32'd0);
            step();
            check("t1_cur_note", 32'(cur1), 32'(rom1[s]));
            rise = -1;
            fall = -1;
            for (int j = 0; j < T1; j++) begin
                if (spk1 && rise < 0) rise = j;
                if (!spk1 && rise >= 0 && fall < 0) fall = j;
                step();
            end
            h = half_period(int'(rom1[s]));
            check($sformatf("t1_rise_note%0d", rom1[s]), rise, (h < T1) ? h : -1);
            check($sformatf("t1_fall_note%0d", rom1[s]), fall, (2 * h < T1) ? 2 * h : -1);
        end
        if (!LOOP) begin
            check("t1_done", 32'(done1), 32'd1);
            check("t1_done_note", 32'(cur1), 32'd0);
        end
        stop1 = 1'b1;
        step();
        stop1 = 1'b0;
        check("t1_stop_busy", 32'(busy1), 32'd0);
    endtask

    // Random-note probe: whole-slot speaker waveform against the tone reference.
    task automatic random_probe();
        int bad;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int s = 0; s <= L2; s++) begin
            check("t2_fetch_spk", 32'(spk2), 32'd0);
            check("t2_addr", 32'(addr2), s);
            step();
            check("t2_latch_spk", 32'(spk2), 32'd0);
            step();
            check("t2_cur_note", 32'(cur2), 32'(rom2[s]));
            bad = 0;
            for (int j = 0; j < T2; j++) begin
                if (spk2 !== exp_spk(int'(rom2[s]), j)) bad++;
                step();
            end
            check($sformatf("t2_wave_note%0d", rom2[s]), bad, 0);
        end
        if (!LOOP) check("t2_done", 32'(done2), 32'd1);
        stop2 = 1'b1;
        step();
        stop2 = 1'b0;
        check("t2_stop_spk", 32'(spk2), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom0[i] = 8'($urandom_range(1, 255));
            rom1[i] = 8'd0;
            rom2[i] = 8'($urandom_range(72, 95));
        end
        rom1[0] = 8'd25;
        rom1[1] = 8'd12;
        rom2[0] = 8'd0;
        rom2[1] = 8'd100;

        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_addr", 32'(addr0), 32'd0);
        check("rst_note", 32'(cur0), 32'd0);
        check("rst_spk", 32'(spk0), 32'd0);
        #20;
        rst_n = 1'b1;
        step();
        check("post_rst_busy", 32'(busy0), 32'd0);

        // Full song with a stray start mid-PLAY, then stop after the song.
        run_song(TOTAL + 9, 9, 1'b0);
        // Stop on the third PLAY cycle of address 2.
        run_song(2 * SLOT + 4, -1, 1'b0);
        // Replay with start held through DONE: restart from the following IDLE cycle.
        run_song(TOTAL + 6, -1, 1'b1);

        // Stop wins over a simultaneous start.
        start0 = 1'b1;
        stop0 = 1'b1;
        step();
        check("startstop_busy", 32'(busy0), 32'd0);
        start0 = 1'b0;
        stop0 = 1'b0;
        step();
        check("startstop_busy2", 32'(busy0), 32'd0);
        check("startstop_addr", 32'(addr0), 32'd0);

        // Asynchronous reset mid-PLAY of address 1.
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (SLOT + 3) step();
        check("pre_rst_addr", 32'(addr0), 32'd1);
        check("pre_rst_busy", 32'(busy0), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy0), 32'd0);
        check("arst_addr", 32'(addr0), 32'd0);
        check("arst_note", 32'(cur0), 32'd0);
        check("arst_spk", 32'(spk0), 32'd0);
        check("arst_done", 32'(done0), 32'd0);
        #20 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rel_busy", 32'(busy0), 32'd0);
            check("rel_addr", 32'(addr0), 32'd0);
        end

        fork
            tone_probe();
            random_probe();
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
